// File: rtl/kv_stream_reader_pkg.sv
// Shared types and constants for the KV/weight-memory read streamer.
// Memory-port bundle, FSM state encoding and default sizing.
package kv_stream_reader_pkg;

  localparam int KV_ADDR_W   = 8;
  localparam int KV_RD_LAT   = 1;
  localparam int KV_WORDLINE = 128;
  localparam int KV_DEPTH    = 4;

  typedef struct packed {
    logic [KV_ADDR_W-1:0]   address;
    logic [KV_WORDLINE-1:0] data;
    logic [KV_WORDLINE-1:0] dout;
    logic                   me;
    logic                   we;
    logic                   oe;
  } kv_cache_packed_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } kv_stream_state_e;

endpackage

// File: rtl/kv_stream_reader_fifo.sv
// Small synchronous FIFO holding wordlines returned by the SRAM.
// Pointers wrap explicitly so DEPTH need not be a power of two.
module stream_fifo
  import kv_stream_reader_pkg::*;
#(
  parameter int WIDTH = KV_WORDLINE,
  parameter int DEPTH = KV_DEPTH,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = push_ok ? inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok ? inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    count    = count_q;
    dout     = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/kv_stream_reader.sv
// Sequential SRAM read streamer feeding the MAC input.
// Credits bound issued reads by free FIFO slots, so backpressure is lossless.
module kv_stream_reader
  import kv_stream_reader_pkg::*;
#(
  parameter int ADDR_W   = KV_ADDR_W,
  parameter int WORDLINE = KV_WORDLINE,
  parameter int RD_LAT   = KV_RD_LAT,
  parameter int DEPTH    = KV_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_base,
  input  logic [ADDR_W:0]     cmd_len,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [WORDLINE-1:0] mem_data,
  output logic                mem_me,
  output logic                mem_we,
  output logic                mem_oe,
  input  logic [WORDLINE-1:0] mem_dout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORDLINE-1:0] out_data,
  output logic                out_last,
  output logic                done,
  output logic                busy
);

  localparam int LW = ADDR_W + 1;
  localparam int CW = $clog2(DEPTH + 1);

  kv_stream_state_e state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LW-1:0]     len_q, len_d;
  logic [LW-1:0]     issue_cnt_q, issue_cnt_d;
  logic [LW-1:0]     beat_cnt_q, beat_cnt_d;
  logic [CW-1:0]     credits_q, credits_d;
  logic [RD_LAT-1:0] tag_q, tag_d;
  logic              done_q, done_d;

  kv_cache_packed_t  mem_bus;
  logic              issue, pop, last_beat;
  logic              fifo_empty, fifo_full;
  logic [CW-1:0]     fifo_count;
  logic              unused_fifo;

  assign unused_fifo = ^{fifo_count, fifo_full};

  always_comb begin
    issue = (state_q == ISSUE)
         && (issue_cnt_q < len_q)
         && (credits_q != '0);
    out_valid = !fifo_empty;
    pop       = out_valid && out_ready;
    last_beat = (beat_cnt_q == len_q - LW'(1));
    out_last  = out_valid && last_beat;

    mem_bus.address = issue
      ? base_q + issue_cnt_q[ADDR_W-1:0] : '0;
    mem_bus.data = '0;
    mem_bus.dout = mem_dout;
    mem_bus.me   = issue;
    mem_bus.we   = 1'b0;
    mem_bus.oe   = issue;

    mem_address = mem_bus.address;
    mem_data    = mem_bus.data;
    mem_me      = mem_bus.me;
    mem_we      = mem_bus.we;
    mem_oe      = mem_bus.oe;

    cmd_ready = (state_q == IDLE);
    done      = done_q;
    busy      = (state_q != IDLE) || (|tag_q);
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    beat_cnt_d  = pop ? beat_cnt_q + LW'(1) : beat_cnt_q;
    done_d      = 1'b0;
    // Credit return by a pop only becomes usable next cycle.
    credits_d   = credits_q - CW'(issue) + CW'(pop);
    tag_d       = tag_q << 1;
    tag_d[0]    = issue;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          base_d      = cmd_base;
          len_d       = cmd_len;
          issue_cnt_d = '0;
          beat_cnt_d  = '0;
          if (cmd_len == '0) done_d  = 1'b1;
          else               state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (issue) begin
          issue_cnt_d = issue_cnt_q + LW'(1);
          if (issue_cnt_q == len_q - LW'(1))
            state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && last_beat) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      beat_cnt_q  <= '0;
      credits_q   <= CW'(DEPTH);
      tag_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      credits_q   <= credits_d;
      tag_q       <= tag_d;
      done_q      <= done_d;
    end
  end

  stream_fifo #(
    .WIDTH(WORDLINE),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (tag_q[RD_LAT-1]),
    .din  (mem_bus.dout),
    .pop  (pop),
    .dout (out_data),
    .count(fifo_count),
    .empty(fifo_empty),
    .full (fifo_full)
  );

endmodule

// File: doc/kv_stream_reader.md
Name: kv_stream_reader

Overview:
Read sequencer that sits directly upstream of the MAC unit. It takes a (base address, length) command, issues sequential single-port SRAM reads on a KV-cache or weight-memory port, absorbs the fixed SRAM read latency, and streams wordlines (N_EMBD/N_HEAD*BIT_W = 128 bits) to the MAC input over a valid/ready interface. Credit-based flow control guarantees that MAC backpressure never drops or reorders data.

Parameters:
ADDR_W, 8, memory address width (KV_ADDR_W); address space is circular, 2^ADDR_W wordlines.
WORDLINE, 128, data width in bits (KV_WORDLINE = MAC_IN_W).
RD_LAT, 1, SRAM read latency in cycles, from mem_me asserted to mem_dout valid; legal range 1..4.
DEPTH, 4, output FIFO depth; must be at least RD_LAT+1; full rate requires DEPTH at least RD_LAT+2.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  high only in IDLE.
cmd_base  in  ADDR_W  first wordline address.
cmd_len  in  ADDR_W+1  number of wordlines, 0..2^ADDR_W.
mem_address  out  ADDR_W  SRAM address.
mem_data  out  WORDLINE  write data, tied to 0.
mem_me  out  1  memory enable; one read per cycle it is high.
mem_we  out  1  always 0 (read-only).
mem_oe  out  1  equals mem_me.
mem_dout  in  WORDLINE  SRAM read data, valid RD_LAT cycles after mem_me.
out_valid  out  1  wordline available to the MAC.
out_ready  in  1  MAC accepts.
out_data  out  WORDLINE  FIFO head.
out_last  out  1  high with the final beat of a command.
done  out  1  one-cycle pulse when a command completes.
busy  out  1  high when not IDLE or when reads are in flight.

Behaviour:
- Reset values: cmd_ready=1 from the first cycle after reset; mem_me, mem_oe, mem_we, mem_address, mem_data, out_valid, out_last, done and busy = 0. FIFO empty, read-valid pipeline cleared, credits=DEPTH.
- FSM IDLE -> ISSUE -> DRAIN -> IDLE.
- IDLE: a command is accepted when cmd_valid and cmd_ready are both high. It latches base and len and clears issue_cnt and beat_cnt. If len is 0, stay in IDLE and pulse done on the next cycle; no memory access and no output beat occur. Otherwise go to ISSUE.
- ISSUE: a read is issued in a cycle only when issue_cnt < len and credits > 0. A read drives mem_me=1 and mem_address = (base + issue_cnt) mod 2^ADDR_W, so the address wraps past all-ones to 0. When the len-th read is issued, go to DRAIN.
- Credits: a credit is consumed on each issue and returned on each output handshake. The credit update is registered: a credit returned by a pop in a cycle cannot be used by an issue in that same cycle. Invariant: fifo_count + inflight + credits = DEPTH. The FIFO never overflows.
- Capture: a RD_LAT-deep valid shift register tags each issue. When the tag emerges, mem_dout is pushed into the FIFO.
- Output:
  - out_valid = FIFO not empty; out_data = FIFO head.
  - A pop happens when out_valid and out_ready are both high.
  - out_data is held stable while out_valid=1 and out_ready=0.
  - out_last = out_valid and (beat_cnt == len-1).
- Latency, command accepted in cycle T: first mem_me in cycle T+1; first out_valid in cycle T+2+RD_LAT.
- Throughput: one beat per cycle when out_ready is held high and DEPTH is at least RD_LAT+2.
- DRAIN: on the handshake of the final beat, return to IDLE and pulse done in the following cycle. cmd_ready rises in that same cycle.
- A cmd_valid raised while busy is held off (cmd_ready=0). There is no queuing inside the block.
- rst asserted mid-command: on the next edge all state returns to reset values. In-flight read data arriving after reset is discarded (tags cleared) and never emitted.

Decomposition:
- Shared package DEFINE_PKG:
  - concrete KV_ADDR_W=8 and KV_RD_LAT=1 values;
  - reuse of KV_CACHE_PACKED for the memory port bundle, with mem_dout mapped to its dout field;
  - KV_STREAM_STATE enum typedef (IDLE, ISSUE, DRAIN).
- One sub-module: stream_fifo, a parameterised synchronous FIFO (WIDTH, DEPTH) with push/pop, count, empty and full, and synchronous active-high rst.

Test Plan:
- base=0x10, len=4, out_ready=1, memory model returns the address in every byte -> mem_address 0x10..0x13 in cycles T+1..T+4; beats 0x10..0x13 in order in cycles T+3..T+6; out_last only on the 4th beat; done in cycle T+7.
- base=0xFE, len=4 -> addresses 0xFE, 0xFF, 0x00, 0x01; out_last on the beat carrying 0x01.
- len=8 with out_ready=0 for 10 cycles, then 1 -> at most DEPTH=4 mem_me pulses before the first pop; all 8 beats delivered exactly once and in order; out_data stable while stalled.
- len=0 -> done pulse in cycle T+1; mem_me never asserts; out_valid stays 0.
- rst for 1 cycle after 3 of 8 reads are issued -> next cycle every output is at its reset value; no stale beat appears; a new command base=0x40, len=2 then completes normally.
- Second cmd_valid held during an active command -> cmd_ready=0 until the done cycle; the second command is accepted then and its first mem_me follows one cycle later.
